mantissa_align_seq: RTL and testbench
=====================================

# mantissa_align_seq

- Alignment stage directly downstream of the exponent subtractor.
- Consumes the subtractor's `exp_disc`, `shift_spaces`, `exp_value` and `out_sign`, plus both hidden-bit mantissas.
- Orders the operands, then right-shifts the smaller-exponent mantissa by the exponent difference, producing guard, round and sticky bits.
- Outputs feed the mantissa adder/subtractor.
- The shift is iterative (one bit per cycle) by default; a compile-time single-cycle barrel option exists.

## Interface
- `MAN_WIDTH`, 23: stored fraction width; mantissa inputs are `MAN_WIDTH+1` bits (hidden bit included).
- `EXP_WIDTH`, 8: exponent width.
- `clk` in 1: single clock, rising edge.
- `rst` in 1: synchronous, active-high reset.
- `in_valid` in 1: input operand set valid.
- `in_ready` out 1: block can accept (IDLE and not in reset).
- `man_a`, `man_b` in `MAN_WIDTH+1`: mantissas with hidden bit.
- `exp_disc` in 2: 10 = A greater, 00 = A less, 11 = equal, 01 = treated as 11.
- `shift_spaces` in `EXP_WIDTH`: unsigned exponent difference.
- `exp_value` in `EXP_WIDTH`: larger exponent, passed through.
- `sign_in` in 1: result sign, passed through.
- `out_valid` out 1: aligned result valid.
- `out_ready` in 1: downstream accepts.
- `man_big` out `MAN_WIDTH+4`: larger-exponent mantissa followed by `3'b000` (G, R, S).
- `man_small` out `MAN_WIDTH+4`: aligned smaller mantissa with {G, R, S} in the low 3 bits.
- `exp_out` out `EXP_WIDTH`: registered `exp_value`.
- `sign_out` out 1: registered `sign_in`.
- `swapped` out 1: 1 when B is the larger-exponent operand.

## Operation
- W = `MAN_WIDTH+4`. States: IDLE, SHIFT, DONE.
- **IDLE**
  - `in_ready`=1.
  - On `in_valid`: capture operands.
  - Operand select:
    - `exp_disc`=00: big = B, small = A, `swapped`=1.
    - Otherwise: big = A, small = B, `swapped`=0.
  - Load `man_big`={big,3'b000} and small register={small,3'b000}.
  - Effective shift cnt = min(`shift_spaces`, W), except `exp_disc` 11/01 forces cnt=0.
  - Next state: SHIFT if cnt>0, else DONE.
- **SHIFT**
  - Each cycle: small <= {1'b0, small[W-1:2], small[1]|small[0]}, so the sticky bit accumulates every bit shifted out. cnt decrements.
  - When cnt reaches 1, that final shift is performed and the next state is DONE.
- **DONE**
  - `out_valid`=1; all outputs held stable.
  - On `out_ready`: go to IDLE.
- Clamp: any `shift_spaces` ≥ W yields `man_small` = 0 except bit0 = OR of the small mantissa.
- No new input is accepted outside IDLE. `in_valid` in SHIFT/DONE is ignored; the upstream stage must hold it.
- Reset (any state, including mid-SHIFT):
  - next state IDLE;
  - `out_valid`=0; `man_big`, `man_small`, `exp_out`, `sign_out`, `swapped` all = 0;
  - the in-flight operation is discarded and never emitted.
- `in_ready`=0 while `rst`=1.

## Timing
- Accept edge = cycle 0.
- `out_valid` rises at cycle 1+cnt (iterative mode), or cycle 1 (fast mode).
- Max iterative latency is W+1 = 28 cycles at default parameters.
- `out_valid` with `out_ready`=1 → IDLE next cycle; `in_ready` is high that cycle. Minimum initiation interval is cnt+2.
- Outputs are registered; no combinational path from inputs to outputs except `in_ready`, which depends on state and `rst`.

## Configuration
- `ALIGN_FAST_EN` defined:
  - In IDLE, the full shift with sticky (sticky = OR of all shifted-out bits) is computed combinationally and registered.
  - The state goes straight to DONE; SHIFT is unreachable; latency is 1 for every shift value.
- `ALIGN_FAST_EN` undefined: iterative one-bit-per-cycle shifter as described above.
- Output values are bit-identical in both modes.

## Test plan
- Basic shift:
  - Stimulus: `man_a`=24'h800000, `man_b`=24'hC00000, `exp_disc`=10, `shift_spaces`=1.
  - Response: `man_big`=27'h4000000, `man_small`=27'h3000000, `swapped`=0.
  - Latency: 2 (1 with fast).
- Sticky accumulation:
  - Stimulus: `man_b`=24'h800001, `exp_disc`=10, shift 4.
  - Response: `man_small`=27'h0400001.
  - Latency: 5 iterative, 1 fast.
- Swap and clamp:
  - Stimulus: `exp_disc`=00, `man_a`=24'hFFFFFF, `man_b`=24'h800000, shift 200.
  - Response: `swapped`=1, `man_big`=27'h4000000, `man_small`=27'h0000001.
  - Latency: 28 iterative.
- Equal exponents:
  - Stimulus: `exp_disc`=11, shift 5 (ignored).
  - Response: `man_small`={`man_b`,3'b000}; latency 1; `exp_out` and `sign_out` equal their captured inputs.
- Backpressure:
  - Stimulus: hold `out_ready`=0 for 3 cycles after `out_valid`.
  - Response: outputs and `out_valid` stable throughout; `in_ready`=0; `in_valid` pulses ignored; IDLE on the cycle after `out_ready`=1.
- Reset mid-SHIFT:
  - Stimulus: assert `rst` at cycle 3 of a shift-20 operation.
  - Response: next cycle all outputs 0, `out_valid` never rises, `in_ready`=1 the cycle after `rst` falls.

Source files
------------

// File: rtl/mantissa_align_seq.sv
// -----------------------------------------------------------------------------
// mantissa_align_seq
//
// Alignment stage that sits between the exponent subtractor and the mantissa
// adder/subtractor. It orders the two operands by exponent and right-shifts the
// smaller-exponent mantissa by the exponent difference. Bits shifted out are
// collected into guard, round and sticky (G, R, S) bits.
//
// By default the shift is iterative, one bit per clock. Defining ALIGN_FAST_EN
// at compile time replaces it with a single-cycle barrel shift. Both modes
// produce bit-identical outputs.
//
// Ports
//   clk           : clock, rising edge
//   rst           : synchronous active-high reset
//   in_valid      : operand set valid
//   in_ready      : block accepts an operand set (IDLE and not in reset)
//   man_a, man_b  : mantissas with hidden bit, MAN_WIDTH+1 bits
//   exp_disc      : 10 = A greater, 00 = A less, 11/01 = equal
//   shift_spaces  : unsigned exponent difference
//   exp_value     : larger exponent, passed through
//   sign_in       : result sign, passed through
//   out_valid     : aligned result valid
//   out_ready     : downstream accepts the result
//   man_big       : {larger-exponent mantissa, 3'b000}
//   man_small     : aligned smaller mantissa, {G, R, S} in the low 3 bits
//   exp_out       : registered exp_value
//   sign_out      : registered sign_in
//   swapped       : 1 when B is the larger-exponent operand
// -----------------------------------------------------------------------------
module mantissa_align_seq #(
    parameter int MAN_WIDTH = 23,
    parameter int EXP_WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [MAN_WIDTH:0]   man_a,
    input  logic [MAN_WIDTH:0]   man_b,
    input  logic [1:0]           exp_disc,
    input  logic [EXP_WIDTH-1:0] shift_spaces,
    input  logic [EXP_WIDTH-1:0] exp_value,
    input  logic                 sign_in,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [MAN_WIDTH+3:0] man_big,
    output logic [MAN_WIDTH+3:0] man_small,
    output logic [EXP_WIDTH-1:0] exp_out,
    output logic                 sign_out,
    output logic                 swapped
);

    localparam int W     = MAN_WIDTH + 4;
    localparam int CNT_W = $clog2(W + 1);
    localparam logic [CNT_W-1:0] W_CNT = CNT_W'(W);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t           state;
    logic [W-1:0]     small_q;

    logic             swap_sel;
    logic [W-1:0]     big_sel;
    logic [W-1:0]     small_sel;
    logic [CNT_W-1:0] eff_cnt;

    // in_ready is the only combinational output; it must drop during reset.
    assign in_ready  = (state == IDLE) && !rst;
    assign man_small = small_q;

    // Operand ordering and effective shift count, evaluated against the live
    // inputs so the IDLE capture edge can load everything at once.
    always_comb begin
        // NOTE: every always_comb output gets a value on every path (here, up
        // front) so no latch is inferred.
        swap_sel  = (exp_disc == 2'b00);
        big_sel   = {(swap_sel ? man_b : man_a), 3'b000};
        small_sel = {(swap_sel ? man_a : man_b), 3'b000};
        eff_cnt   = '0;
        // exp_disc[0] set means equal exponents (11, and 01 treated as 11).
        if (!exp_disc[0]) begin
            // A shift of W or more moves every bit into sticky; clamping to W
            // bounds both the iterative latency and the barrel shift amount.
            if (32'(shift_spaces) >= 32'(W)) begin
                eff_cnt = W_CNT;
            end else begin
                eff_cnt = CNT_W'(shift_spaces);
            end
        end
    end

`ifdef ALIGN_FAST_EN
    logic [W-1:0] fast_small;
    logic         fast_sticky;

    // Single-cycle equivalent of eff_cnt iterations: bit0 of the result is
    // the OR of every bit that leaves the register plus the bit landing there.
    always_comb begin
        fast_sticky = 1'b0;
        for (int i = 0; i < W; i++) begin
            if (i < int'(eff_cnt)) begin
                fast_sticky = fast_sticky | small_sel[i];
            end
        end
        fast_small    = small_sel >> eff_cnt;
        fast_small[0] = fast_small[0] | fast_sticky;
    end
`else
    logic [CNT_W-1:0] cnt;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: sequential state uses non-blocking assignments only, so
            // every register samples the pre-edge values of the others.
            state     <= IDLE;
            out_valid <= 1'b0;
            man_big   <= '0;
            small_q   <= '0;
            exp_out   <= '0;
            sign_out  <= 1'b0;
            swapped   <= 1'b0;
`ifndef ALIGN_FAST_EN
            cnt       <= '0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        man_big  <= big_sel;
                        exp_out  <= exp_value;
                        sign_out <= sign_in;
                        swapped  <= swap_sel;
`ifdef ALIGN_FAST_EN
                        small_q   <= fast_small;
                        state     <= DONE;
                        out_valid <= 1'b1;
`else
                        small_q <= small_sel;
                        cnt     <= eff_cnt;
                        if (eff_cnt == '0) begin
                            state     <= DONE;
                            out_valid <= 1'b1;
                        end else begin
                            state <= SHIFT;
                        end
`endif
                    end
                end

                SHIFT: begin
`ifdef ALIGN_FAST_EN
                    // Unreachable with the barrel shifter.
                    state <= IDLE;
`else
                    // The old round bit is folded into sticky, so sticky keeps
                    // the OR of everything shifted past the guard position.
                    small_q <= {1'b0, small_q[W-1:2], small_q[1] | small_q[0]};
                    cnt     <= cnt - 1'b1;
                    if (cnt == CNT_W'(1)) begin
                        state     <= DONE;
                        out_valid <= 1'b1;
                    end
`endif
                end

                DONE: begin
                    // Outputs hold until the consumer takes them.
                    if (out_ready) begin
                        state     <= IDLE;
                        out_valid <= 1'b0;
                    end
                end

                default: begin
                    state     <= IDLE;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mantissa_align_seq.sv
// -----------------------------------------------------------------------------
// tb_mantissa_align_seq
//
// Directed and random stimulus for mantissa_align_seq. Expected values come
// from hard-coded constants or from an arithmetic model of the alignment
// (plain shift of the extended mantissa, OR of the lost bits into bit 0).
// -----------------------------------------------------------------------------
module tb_mantissa_align_seq;

    localparam int MW = 23;
    localparam int EW = 8;
    localparam int W  = MW + 4;

    logic          clk;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [MW:0]   man_a;
    logic [MW:0]   man_b;
    logic [1:0]    exp_disc;
    logic [EW-1:0] shift_spaces;
    logic [EW-1:0] exp_value;
    logic          sign_in;
    logic          out_valid;
    logic          out_ready;
    logic [W-1:0]  man_big;
    logic [W-1:0]  man_small;
    logic [EW-1:0] exp_out;
    logic          sign_out;
    logic          swapped;

    int total = 0;
    int bad   = 0;

    mantissa_align_seq #(.MAN_WIDTH(MW), .EXP_WIDTH(EW)) dut (
        .clk          (clk),
        .rst          (rst),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .man_a        (man_a),
        .man_b        (man_b),
        .exp_disc     (exp_disc),
        .shift_spaces (shift_spaces),
        .exp_value    (exp_value),
        .sign_in      (sign_in),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .man_big      (man_big),
        .man_small    (man_small),
        .exp_out      (exp_out),
        .sign_out     (sign_out),
        .swapped      (swapped)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // Latency from the accept edge (counted as edge 0) to the first edge at
    // which out_valid is seen high.
    function automatic int lat_of(input logic [1:0] disc, input logic [7:0] sh);
        int s;
        s = (disc == 2'b11 || disc == 2'b01) ? 0 : ((int'(sh) >= W) ? W : int'(sh));
`ifdef ALIGN_FAST_EN
        s = 0;
`endif
        return 1 + s;
    endfunction

    // Arithmetic reference: shift the {mantissa,000} value right and fold
    // every discarded bit into bit 0.
    function automatic logic [W-1:0] model_small(input logic [MW:0] a, input logic [MW:0] b,
                                                 input logic [1:0] disc, input logic [7:0] sh);
        longint unsigned ext;
        longint unsigned mask;
        longint unsigned st;
        int s;
        ext = (disc == 2'b00) ? 64'(a) : 64'(b);
        ext = ext * 8;
        s   = (disc == 2'b11 || disc == 2'b01) ? 0 : int'(sh);
        if (s >= W) return (ext != 0) ? W'(1) : W'(0);
        mask = (64'd1 << s) - 64'd1;
        st   = ((ext & mask) != 0) ? 64'd1 : 64'd0;
        return W'((ext >> s) | st);
    endfunction

    // Present an operand set, wait (bounded) for out_valid and report latency.
    task automatic issue(input logic [MW:0] a, input logic [MW:0] b, input logic [1:0] disc,
                         input logic [7:0] sh, input logic [7:0] ev, input logic sg,
                         output int lat);
        check("in_ready_idle", 64'(in_ready), 64'd1);
        man_a = a; man_b = b; exp_disc = disc; shift_spaces = sh;
        exp_value = ev; sign_in = sg; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic run(input string tag, input logic [MW:0] a, input logic [MW:0] b,
                       input logic [1:0] disc, input logic [7:0] sh, input logic [7:0] ev,
                       input logic sg, input logic [W-1:0] e_big, input logic [W-1:0] e_small,
                       input logic e_swap, input int e_lat);
        int lat;
        issue(a, b, disc, sh, ev, sg, lat);
        check({tag, "_valid"}, 64'(out_valid), 64'd1);
        check({tag, "_lat"}, 64'(lat), 64'(e_lat));
        check({tag, "_big"}, 64'(man_big), 64'(e_big));
        check({tag, "_small"}, 64'(man_small), 64'(e_small));
        check({tag, "_swap"}, 64'(swapped), 64'(e_swap));
        check({tag, "_exp"}, 64'(exp_out), 64'(ev));
        check({tag, "_sign"}, 64'(sign_out), 64'(sg));
        // out_ready is high: back to IDLE on the next edge.
        @(posedge clk); #1;
        check({tag, "_idle_ready"}, 64'(in_ready), 64'd1);
        check({tag, "_idle_valid"}, 64'(out_valid), 64'd0);
    endtask

    initial begin
        logic [MW:0] ra;
        logic [MW:0] rb;
        logic [1:0]  rd;
        logic [7:0]  rs;
        logic [7:0]  re;
        logic        rg;
        int          lat;
        bit          saw_valid;

        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        man_a = '0; man_b = '0; exp_disc = 2'b10; shift_spaces = '0;
        exp_value = '0; sign_in = 1'b0;

        // Reset state
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("rst_in_ready", 64'(in_ready), 64'd0);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_man_big", 64'(man_big), 64'd0);
        check("rst_man_small", 64'(man_small), 64'd0);
        check("rst_exp_out", 64'(exp_out), 64'd0);
        check("rst_sign_swap", 64'({sign_out, swapped}), 64'd0);
        rst = 1'b0;
        #1;
        check("post_rst_in_ready", 64'(in_ready), 64'd1);
        @(posedge clk); #1;

        // Basic shift by one
        run("basic", 24'h800000, 24'hC00000, 2'b10, 8'd1, 8'h81, 1'b0,
            27'h4000000, 27'h3000000, 1'b0, lat_of(2'b10, 8'd1));

        // Sticky accumulation
        run("sticky", 24'hFFFFFF, 24'h800001, 2'b10, 8'd4, 8'h90, 1'b1,
            27'h7FFFFF8, 27'h0400001, 1'b0, lat_of(2'b10, 8'd4));

        // Swap and clamp (iterative latency 28)
        run("clamp", 24'hFFFFFF, 24'h800000, 2'b00, 8'd200, 8'hC8, 1'b0,
            27'h4000000, 27'h0000001, 1'b1, lat_of(2'b00, 8'd200));

        // Equal exponents, shift ignored
        run("equal", 24'h900000, 24'hABCDEF, 2'b11, 8'd5, 8'h7E, 1'b1,
            27'h4800000, 27'h55E6F78, 1'b0, 1);

        // 01 is treated as equal
        run("disc01", 24'hA00000, 24'hF0F0F1, 2'b01, 8'd9, 8'h10, 1'b0,
            27'h5000000, 27'h7878788, 1'b0, 1);

        // Shift of exactly W-1: only the hidden bit reaches bit 0 plus sticky
        run("shift26", 24'h800000, 24'h800000, 2'b10, 8'd26, 8'h22, 1'b0,
            27'h4000000, 27'h0000001, 1'b0, lat_of(2'b10, 8'd26));

        // Backpressure: out_ready low for 3 cycles after out_valid
        out_ready = 1'b0;
        issue(24'hC00000, 24'hE00000, 2'b10, 8'd2, 8'h55, 1'b1, lat);
        check("bp_lat", 64'(lat), 64'(lat_of(2'b10, 8'd2)));
        check("bp_valid0", 64'(out_valid), 64'd1);
        for (int i = 0; i < 3; i++) begin
            man_a = 24'h812345; man_b = 24'hFFFFFF; exp_disc = 2'b00;
            shift_spaces = 8'd1; in_valid = 1'b1;
            @(posedge clk); #1;
            check("bp_valid", 64'(out_valid), 64'd1);
            check("bp_small", 64'(man_small), 64'(27'h1C00000));
            check("bp_big", 64'(man_big), 64'(27'h6000000));
            check("bp_in_ready", 64'(in_ready), 64'd0);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        check("bp_idle_ready", 64'(in_ready), 64'd1);
        check("bp_idle_valid", 64'(out_valid), 64'd0);
        @(posedge clk); #1;
        check("bp_no_ghost", 64'(out_valid), 64'd0);

        // Random operands against the arithmetic model
        for (int n = 0; n < 40; n++) begin
            ra = {1'b1, 23'($urandom)};
            rb = {1'b1, 23'($urandom)};
            rd = 2'($urandom_range(0, 3));
            rs = ($urandom_range(0, 9) == 0) ? 8'($urandom_range(27, 255)) : 8'($urandom_range(0, 30));
            re = 8'($urandom);
            rg = 1'($urandom);
            run("rand", ra, rb, rd, rs, re, rg,
                {(rd == 2'b00) ? rb : ra, 3'b000}, model_small(ra, rb, rd, rs),
                (rd == 2'b00), lat_of(rd, rs));
        end

        // Reset in the middle of a shift-20 operation
        man_a = 24'hFFFFFF; man_b = 24'hFFFFFF; exp_disc = 2'b10; shift_spaces = 8'd20;
        exp_value = 8'hAA; sign_in = 1'b1; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        check("mid_rst_in_ready", 64'(in_ready), 64'd0);
        @(posedge clk); #1;
        check("mid_rst_valid", 64'(out_valid), 64'd0);
        check("mid_rst_big", 64'(man_big), 64'd0);
        check("mid_rst_small", 64'(man_small), 64'd0);
        check("mid_rst_exp", 64'(exp_out), 64'd0);
        check("mid_rst_sign_swap", 64'({sign_out, swapped}), 64'd0);
        rst = 1'b0;
        #1;
        check("mid_rst_ready_after", 64'(in_ready), 64'd1);
        saw_valid = 1'b0;
        for (int i = 0; i < 35; i++) begin
            @(posedge clk); #1;
            if (out_valid) saw_valid = 1'b1;
        end
        check("mid_rst_never_valid", 64'(saw_valid), 64'd0);

        // Recovery after reset
        run("recover", 24'h800000, 24'hC00000, 2'b10, 8'd3, 8'h01, 1'b0,
            27'h4000000, 27'h0C00000, 1'b0, lat_of(2'b10, 8'd3));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
